// File: rtl/uart_transmitter_if.sv
// Host-side write port of the UART transmitter: byte push plus FIFO/line status.
// A byte is taken on a rising clk edge when wr_en=1 and full=0; with full=1 it is dropped, and no stall or retry follows.
interface uart_transmitter_if;
  logic       wr_en;
  logic [7:0] data_in;
  logic       full;
  logic       empty;
  logic       busy;

  modport master (output wr_en, output data_in, input full, input empty, input busy);
  modport slave  (input wr_en, input data_in, output full, output empty, output busy);
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: a small FIFO feeds an 8N1/8N2 serialiser.
// Line timing is paced by the shared oversampling enable.
module uart_transmitter #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  uart_transmitter_if.slave   host,
  output logic                tx,
  output logic [1:0]          state_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [4:0] BIT_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_LAST = 5'(STOP_BITS * OVERSAMPLE - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_e;

  state_e          state_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, empty_q;
  logic            push, pop;
  logic [4:0]      tick_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            tx_q;

  // full is sampled before any pop, so a write on a full FIFO is dropped even if a pop frees a slot.
  assign push = host.wr_en && !full_q;
  assign pop  = clk_en && !empty_q &&
                ((state_q == IDLE) || ((state_q == STOP) && (tick_q == STOP_LAST)));

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= host.data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(FIFO_DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rptr_q];
            tick_q  <= '0;
            bit_q   <= '0;
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: if (clk_en) begin
          if (tick_q == BIT_LAST) begin
            tick_q  <= '0;
            bit_q   <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            tick_q <= tick_q + 5'd1;
          end
        end
        DATA: if (clk_en) begin
          if (tick_q == BIT_LAST) begin
            tick_q <= '0;
            if (bit_q == DATA_LAST) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              shift_q <= shift_q >> 1;
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[1];
            end
          end else begin
            tick_q <= tick_q + 5'd1;
          end
        end
        STOP: if (clk_en) begin
          if (tick_q == STOP_LAST) begin
            tick_q <= '0;
            bit_q  <= '0;
            // Next byte already queued: chain straight into its start bit.
            if (pop) begin
              shift_q <= mem_q[rptr_q];
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            tick_q <= tick_q + 5'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx         = tx_q;
  assign state_o    = state_q;
  assign host.full  = full_q;
  assign host.empty = empty_q;
  assign host.busy  = (state_q != IDLE) || !empty_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: frame-level line model, serial receiver and directed scenarios.
module tb_uart_transmitter;
  localparam int DB = 8, OS = 16, SB = 1, DEPTH = 4;
  localparam int FRAME = (1 + DB + SB) * OS;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clk_en = 1'b0;
  logic       tx;
  logic [1:0] state_o;
  int         errors = 0;
  int         checks = 0;

  uart_transmitter_if hif ();

  uart_transmitter #(.DATA_BITS(DB), .OVERSAMPLE(OS), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .host(hif), .tx(tx), .state_o(state_o));

  // ---------------- clock / enable ----------------
  always #5 clk = ~clk;

  int en_mode = 1;  // 0 off, 1 every cycle, 2 every 5th cycle
  int en_div  = 0;
  always @(negedge clk) begin
    en_div = (en_div == 4) ? 0 : en_div + 1;
    clk_en = (en_mode == 1) || (en_mode == 2 && en_div == 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  logic [7:0] mq[$];
  logic [7:0] m_cur;
  bit         m_active = 0;
  int         m_pos = 0;
  bit         m_was_full;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_active = 0;
      m_pos    = 0;
    end else begin
      m_was_full = (mq.size() == DEPTH);
      if (clk_en) begin
        if (m_active) begin
          m_pos++;
          if (m_pos == FRAME) m_active = 0;
        end
        if (!m_active && mq.size() > 0) begin
          m_cur    = mq.pop_front();
          m_active = 1;
          m_pos    = 0;
        end
      end
      if (hif.wr_en && !m_was_full) mq.push_back(hif.data_in);
    end
  end

  function automatic logic m_tx();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_pos / OS;
    if (idx == 0) return 1'b0;
    if (idx <= DB) return m_cur[idx-1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      check("tx",    tx,        m_tx());
      check("full",  hif.full,  mq.size() == DEPTH);
      check("empty", hif.empty, mq.size() == 0);
      check("busy",  hif.busy,  m_active || mq.size() != 0);
    end
  end

  // ---------------- serial receiver + line statistics ----------------
  logic [7:0] rx_q[$];
  logic [7:0] rx_byte;
  bit         rx_active = 0;
  int         rx_pos = 0;
  bit         en_seen = 0;
  int         low_run = 0;
  bit         low_active = 0;
  int         busy_run = 0;
  int         k;

  always @(posedge clk) en_seen = clk_en;

  always @(negedge clk) begin
    if (!rst) begin
      rx_active  = 0;
      low_active = 0;
    end else begin
      if (low_active) begin
        if (tx === 1'b0) low_run++;
        else low_active = 0;
      end
      if (hif.busy && (busy_run > 0 || tx === 1'b0)) busy_run++;
      if (!rx_active) begin
        if (tx === 1'b0) begin
          rx_active  = 1;
          rx_pos     = 0;
          low_active = 1;
          low_run    = 1;
        end
      end else if (en_seen) begin
        rx_pos++;
        if (rx_pos % OS == OS / 2) begin
          k = rx_pos / OS;
          if (k == 0) check("rx_start", tx, 1'b0);
          else if (k <= DB) rx_byte[k-1] = tx;
          else begin
            check("rx_stop", tx, 1'b1);
            rx_q.push_back(rx_byte);
            rx_active = 0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_bytes(input logic [7:0] b[$]);
    foreach (b[i]) begin
      @(negedge clk);
      hif.wr_en   = 1'b1;
      hif.data_in = b[i];
    end
    @(negedge clk);
    hif.wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((hif.busy || rx_active) && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (hif.busy || rx_active) begin
      errors++;
      $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0", hif.busy, max);
    end
  endtask

  task automatic check_rx(input string name, input logic [7:0] exp[$]);
    check({name, "_count"}, rx_q.size(), exp.size());
    foreach (exp[i]) begin
      if (rx_q.size() > 0) check({name, "_byte"}, rx_q.pop_front(), exp[i]);
    end
    rx_q.delete();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    hif.wr_en   = 1'b0;
    hif.data_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx",    tx,        1'b1);
    check("rst_full",  hif.full,  1'b0);
    check("rst_empty", hif.empty, 1'b1);
    check("rst_busy",  hif.busy,  1'b0);
    @(posedge clk); #3 rst = 1'b1;
    repeat (2) @(negedge clk);

    // single byte 0xA5
    busy_run = 0;
    write_bytes('{8'hA5});
    wait_idle(400);
    check("a5_start_low", low_run, 16);
    check("a5_busy_len",  busy_run, 160);
    check_rx("a5", '{8'hA5});

    // back-to-back frames
    busy_run = 0;
    write_bytes('{8'h00, 8'hFF, 8'h55});
    wait_idle(1000);
    check("b2b_busy_len", busy_run, 480);
    check_rx("b2b", '{8'h00, 8'hFF, 8'h55});

    // overflow with the enable held off
    en_mode = 0;
    repeat (2) @(negedge clk);
    write_bytes('{8'h01, 8'h02, 8'h03, 8'h04});
    check("ovf_full4", hif.full, 1'b1);
    write_bytes('{8'h05, 8'h06});
    check("ovf_full6", hif.full, 1'b1);
    busy_run = 0;
    en_mode  = 1;
    wait_idle(1000);
    check_rx("ovf", '{8'h01, 8'h02, 8'h03, 8'h04});

    // gapped enable: one pulse every 5 cycles
    en_mode  = 2;
    busy_run = 0;
    write_bytes('{8'h3C});
    wait_idle(2000);
    check("gap_low_run",  low_run, 240);
    check("gap_busy_len", busy_run, 800);
    check_rx("gap", '{8'h3C});

    // asynchronous reset during data bit 3
    en_mode = 1;
    repeat (2) @(negedge clk);
    write_bytes('{8'hC3});
    for (int i = 0; i < 200 && !(rx_active && rx_pos >= 4 * OS + 5); i++) @(negedge clk);
    check("rst_reached_bit3", rx_active && rx_pos >= 4 * OS + 5, 1'b1);
    @(posedge clk); #3 rst = 1'b0;
    #1;
    check("mid_rst_tx",    tx,        1'b1);
    check("mid_rst_empty", hif.empty, 1'b1);
    check("mid_rst_busy",  hif.busy,  1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk); #3 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_rx("aborted", '{});
    busy_run = 0;
    write_bytes('{8'h81});
    wait_idle(400);
    check_rx("post_rst", '{8'h81});

    // loopback of four bytes into the serial receiver
    write_bytes('{8'h00, 8'hFF, 8'hA5, 8'h5A});
    wait_idle(1200);
    check_rx("loop", '{8'h00, 8'hFF, 8'hA5, 8'h5A});

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
